// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth multiplier feeder.
package booth_pkg;

  localparam int unsigned DataWidth  = 8;
  // Cycles from START rising to Done, and the issue-to-issue period.
  localparam int unsigned MulLatency = 19;
  localparam int unsigned MulPeriod  = 20;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StErr
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide even when full.
module sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/booth_mul_feeder.sv
// Operand/result sequencer around an 8-bit sequential Booth multiplier with
// credit-based issue so that no product is ever dropped.
module booth_mul_feeder
  import booth_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DataWidth,
  parameter int unsigned OP_DEPTH  = 4,
  parameter int unsigned RES_DEPTH = 2,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [DATAWIDTH-1:0]   IN_A,
  input  logic [DATAWIDTH-1:0]   IN_B,
  output logic                   MUL_START,
  output logic [DATAWIDTH-1:0]   MUL_A,
  output logic [DATAWIDTH-1:0]   MUL_B,
  input  logic [2*DATAWIDTH-1:0] MUL_RESULT,
  input  logic                   MUL_DONE,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [2*DATAWIDTH-1:0] OUT_P,
  output logic                   BUSY,
  output logic                   ERR
);

  localparam int unsigned PairW   = 2 * DATAWIDTH;
  localparam int unsigned OpCntW  = $clog2(OP_DEPTH + 1);
  localparam int unsigned ResCntW = $clog2(RES_DEPTH + 1);
  localparam int unsigned ResNxtW = ResCntW + 1;
  localparam int unsigned TimerW  = $clog2(TIMEOUT + 1);

  state_e                 state_q;
  logic [TimerW-1:0]      timer_q;
  logic                   mul_start_q, busy_q, err_q;
  logic [DATAWIDTH-1:0]   mul_a_q, mul_b_q;

  logic [PairW-1:0]       op_head;
  logic [OpCntW-1:0]      op_count;
  logic [ResCntW-1:0]     res_count;
  logic [ResNxtW-1:0]     res_count_next;
  logic                   op_push, op_avail, res_push, res_pop, credit, issue;

  assign IN_READY = (op_count != OpCntW'(OP_DEPTH));
  assign op_push  = IN_VALID && IN_READY;
  assign op_avail = (op_count != '0);
  assign OUT_VALID = (res_count != '0);
  assign res_pop  = OUT_VALID && OUT_READY;
  assign res_push = (state_q == StRun) && MUL_DONE;

  // Reserve a result slot for the product of the operation being issued.
  always_comb begin
    res_count_next = ResNxtW'(res_count) + ResNxtW'(res_push) - ResNxtW'(res_pop);
    credit         = (res_count_next < ResNxtW'(RES_DEPTH));
    issue          = op_avail && credit && ((state_q == StIdle) || res_push);
  end

  sync_fifo #(
    .Width (PairW),
    .Depth (OP_DEPTH)
  ) u_op_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .push_i  (op_push),
    .data_i  ({IN_A, IN_B}),
    .pop_i   (issue),
    .data_o  (op_head),
    .count_o (op_count)
  );

  sync_fifo #(
    .Width (PairW),
    .Depth (RES_DEPTH)
  ) u_res_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .push_i  (res_push),
    .data_i  (MUL_RESULT),
    .pop_i   (res_pop),
    .data_o  (OUT_P),
    .count_o (res_count)
  );

  // START stays high through the Done cycle; the multiplier clears Done on that edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue) begin
            {mul_a_q, mul_b_q} <= op_head;
            mul_start_q        <= 1'b1;
            busy_q             <= 1'b1;
            timer_q            <= '0;
            state_q            <= StRun;
          end
        end
        StRun: begin
          if (MUL_DONE) begin
            if (issue) begin
              {mul_a_q, mul_b_q} <= op_head;
              timer_q            <= '0;
            end else begin
              mul_start_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end
          end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
            err_q       <= 1'b1;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StErr;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StErr: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MUL_START = mul_start_q;
  assign MUL_A     = mul_a_q;
  assign MUL_B     = mul_b_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_booth_mul_feeder.sv
// Directed bench for booth_mul_feeder paired with a behavioural Booth multiplier.
module tb_booth_mul_feeder;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b, mul_a, mul_b;
  logic        mul_start, mul_done, out_valid, out_ready, busy, err;
  logic [15:0] mul_result, out_p;

  int checks = 0;
  int errors = 0;

  logic [7:0]  va [6];
  logic [7:0]  vb [6];
  logic [15:0] ve [6];

  booth_mul_feeder #(
    .DATAWIDTH (8),
    .OP_DEPTH  (4),
    .RES_DEPTH (2),
    .TIMEOUT   (32)
  ) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .IN_A       (in_a),
    .IN_B       (in_b),
    .MUL_START  (mul_start),
    .MUL_A      (mul_a),
    .MUL_B      (mul_b),
    .MUL_RESULT (mul_result),
    .MUL_DONE   (mul_done),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .OUT_P      (out_p),
    .BUSY       (busy),
    .ERR        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: loads one edge after START is seen, Done 19 cycles after START rose.
  logic [4:0]  m_cnt;
  logic [15:0] m_prod;
  logic        done_en;
  int          n_loads;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= '0;
      m_prod <= '0;
    end else if (m_cnt == 5'd0) begin
      if (mul_start) begin
        m_cnt   <= 5'd1;
        m_prod  <= $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});
        n_loads <= n_loads + 1;
      end
    end else if (m_cnt == 5'd19) begin
      m_cnt <= '0;
    end else begin
      m_cnt <= m_cnt + 5'd1;
    end
  end

  assign mul_done   = done_en && (m_cnt == 5'd19);
  assign mul_result = m_prod;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_b2b(input string tag);
    int  nres = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    bit  started = 0;
    bit  gap = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(va[i], vb[i]);
    while (nres < 4 && cyc < 150) begin
      if (mul_start) started = 1;
      if (out_valid) begin
        chk($sformatf("%s_p%0d", tag, nres), 32'(out_p), 32'(ve[nres]));
        if (nres > 0) chk($sformatf("%s_spacing%0d", tag, nres), cyc - last_cyc, 32'd20);
        last_cyc = cyc;
        nres++;
      end
      if (started && nres < 4 && !mul_start) gap = 1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, nres, 32'd4);
    chk({tag, "_start_continuous"}, 32'(gap), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic collect(input string tag, input int n);
    int nres = 0;
    int cyc = 0;
    out_ready = 1'b1;
    while (nres < n && cyc < 300) begin
      if (out_valid) begin
        chk($sformatf("%s_p%0d", tag, nres), 32'(out_p), 32'(ve[nres]));
        nres++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, nres, n);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int loads0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    done_en   = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single operation 3 * -5
    push(8'h03, 8'hFB);
    chk("single_start_pre", 32'(mul_start), 32'd0);
    @(negedge clk);
    chk("single_start", 32'(mul_start), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_ab", 32'({mul_a, mul_b}), 32'h03FB);
    repeat (18) @(negedge clk);
    chk("single_done_pre", 32'(mul_done), 32'd0);
    @(negedge clk);
    chk("single_done", 32'(mul_done), 32'd1);
    chk("single_start_in_done", 32'(mul_start), 32'd1);
    chk("single_out_valid_pre", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_p", 32'(out_p), 32'hFFF1);
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_start_end", 32'(mul_start), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("single_drained", 32'(out_valid), 32'd0);

    // Back-to-back
    va[0] = 8'h02; vb[0] = 8'h03; ve[0] = 16'h0006;
    va[1] = 8'hFC; vb[1] = 8'h05; ve[1] = 16'hFFEC;
    va[2] = 8'h07; vb[2] = 8'hF9; ve[2] = 16'hFFCF;
    va[3] = 8'hFD; vb[3] = 8'hF7; ve[3] = 16'h001B;
    run_b2b("b2b");

    // Corner operands
    va[0] = 8'h80; vb[0] = 8'h80; ve[0] = 16'h4000;
    va[1] = 8'h7F; vb[1] = 8'h80; ve[1] = 16'hC080;
    va[2] = 8'h00; vb[2] = 8'hFF; ve[2] = 16'h0000;
    va[3] = 8'hFF; vb[3] = 8'hFF; ve[3] = 16'h0001;
    run_b2b("corner");
    repeat (3) @(negedge clk);

    // Backpressure: only two issues fit the result buffer
    va[0] = 8'h05; vb[0] = 8'h06; ve[0] = 16'h001E;
    va[1] = 8'hFE; vb[1] = 8'h09; ve[1] = 16'hFFEE;
    va[2] = 8'h0A; vb[2] = 8'hF6; ve[2] = 16'hFF9C;
    va[3] = 8'hF9; vb[3] = 8'hF8; ve[3] = 16'h0038;
    va[4] = 8'h0C; vb[4] = 8'h0C; ve[4] = 16'h0090;
    va[5] = 8'h9C; vb[5] = 8'h03; ve[5] = 16'hFED4;
    loads0 = n_loads;
    for (int i = 0; i < 4; i++) push(va[i], vb[i]);
    repeat (60) @(negedge clk);
    chk("bp_issues", n_loads - loads0, 32'd2);
    chk("bp_start_low", 32'(mul_start), 32'd0);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_p), 32'h001E);
    chk("bp_in_ready_2", 32'(in_ready), 32'd1);
    push(va[4], vb[4]);
    chk("bp_in_ready_3", 32'(in_ready), 32'd1);
    push(va[5], vb[5]);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_issues_hold", n_loads - loads0, 32'd2);
    collect("bp", 6);
    repeat (3) @(negedge clk);
    chk("bp_in_ready_end", 32'(in_ready), 32'd1);

    // Reset mid-operation with a second operand queued
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    chk("rstmid_start", 32'(mul_start), 32'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_start_low", 32'(mul_start), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_no_reissue", 32'(mul_start), 32'd0);

    // Timeout
    done_en = 1'b0;
    push(8'h09, 8'h09);
    @(negedge clk);
    chk("to_start", 32'(mul_start), 32'd1);
    repeat (31) @(negedge clk);
    chk("to_err_pre", 32'(err), 32'd0);
    chk("to_start_pre", 32'(mul_start), 32'd1);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_start_drop", 32'(mul_start), 32'd0);
    push(8'h02, 8'h02);
    repeat (10) @(negedge clk);
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_no_issue", 32'(mul_start), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("to_err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    done_en = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
